// File: rtl/mac_arb_pkg.sv
// Shared types and constants for the Tx MAC input arbiter and related schedulers.
package mac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    ABORT
  } arb_state_t;

  // Byte enables driven on the synthetic abort beat.
  localparam logic [7:0] ABORT_KEEP = 8'hFF;

  // Width of an index into n things; never zero so single-entry configs stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_select
  import mac_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    winner,
  output logic [IdxW-1:0] idx,
  output logic            any_valid
);

  logic [31:0] cand;

  // Walk the requests starting at ptr; the first hit wins. Explicit wrap keeps
  // non-power-of-two N correct.
  always_comb begin
    winner    = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(ptr) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any_valid && req[cand[IdxW-1:0]]) begin
        any_valid                = 1'b1;
        winner[cand[IdxW-1:0]]   = 1'b1;
        idx                      = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter feeding the Tx MAC AXIS input, with a stall
// watchdog that terminates a stuck frame with an error beat and drains the
// remainder of that frame from its source.
module tx_frame_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned DATA_BYTES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N_REQ*DATA_BYTES*8-1:0] s_axis_tdata,
  input  logic [N_REQ*DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic [N_REQ-1:0]              s_axis_tvalid,
  input  logic [N_REQ-1:0]              s_axis_tlast,
  output logic [N_REQ-1:0]              s_axis_tready,
  output logic [DATA_BYTES*8-1:0]       m00_axis_tdata,
  output logic [DATA_BYTES-1:0]         m00_axis_tkeep,
  output logic                          m00_axis_tvalid,
  output logic                          m00_axis_tlast,
  output logic                          m00_axis_tuser,
  input  logic                          m00_axis_tready,
  output logic [N_REQ-1:0]              o_grant,
  output logic                          o_abort
);

  localparam int unsigned DataW  = DATA_BYTES * 8;
  localparam int unsigned IdxW   = idx_width(N_REQ);
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t        state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  drop_q, drop_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      win_onehot;
  logic [IdxW-1:0]       win_idx;
  logic                  win_any;
  logic                  src_valid;
  logic                  src_last;
  logic [DataW-1:0]      src_data;
  logic [DATA_BYTES-1:0] src_keep;
  logic [IdxW-1:0]       next_ptr;

  // Sources draining an aborted frame may not compete until that frame ends.
  assign eligible = s_axis_tvalid & ~drop_q;

  rr_select #(
    .N(N_REQ)
  ) u_rr_select (
    .req      (eligible),
    .ptr      (rr_ptr_q),
    .winner   (win_onehot),
    .idx      (win_idx),
    .any_valid(win_any)
  );

  assign src_valid = s_axis_tvalid[owner_q];
  assign src_last  = s_axis_tlast[owner_q];
  assign src_data  = s_axis_tdata[owner_q * DataW +: DataW];
  assign src_keep  = s_axis_tkeep[owner_q * DATA_BYTES +: DATA_BYTES];
  assign next_ptr  = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign o_grant   = grant_q;

  // Output mux: pass-through of the owner in FWD, synthetic error beat in ABORT.
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tkeep  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tuser  = 1'b0;
    s_axis_tready   = drop_q;
    o_abort         = 1'b0;
    case (state_q)
      FWD: begin
        m00_axis_tdata         = src_data;
        m00_axis_tkeep         = src_keep;
        m00_axis_tvalid        = src_valid;
        m00_axis_tlast         = src_last;
        s_axis_tready[owner_q] = m00_axis_tready;
      end
      ABORT: begin
        m00_axis_tvalid        = 1'b1;
        // All lanes enabled on the abort beat.
        m00_axis_tkeep         = {DATA_BYTES{ABORT_KEEP[0]}};
        m00_axis_tlast         = 1'b1;
        m00_axis_tuser         = 1'b1;
        s_axis_tready[owner_q] = 1'b0;
        o_abort                = m00_axis_tready;
      end
      default: ;
    endcase
  end

  // Next-state: arbitration, frame completion, watchdog and drop bookkeeping.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    timer_d  = timer_q;
    // A draining source leaves drop mode on its discarded tlast beat.
    drop_d   = drop_q & ~(s_axis_tvalid & s_axis_tlast);
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = FWD;
          owner_d = win_idx;
          grant_d = win_onehot;
          timer_d = '0;
        end
      end
      FWD: begin
        if (src_valid && m00_axis_tready) begin
          timer_d = '0;
          if (src_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
            grant_d  = '0;
          end
        end else if (!src_valid && (TIMEOUT_CYCLES != 0)) begin
          // Only source starvation counts; downstream backpressure never aborts.
          if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ABORT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ABORT: begin
        if (m00_axis_tready) begin
          state_d         = IDLE;
          rr_ptr_d        = next_ptr;
          grant_d         = '0;
          drop_d[owner_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      drop_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      drop_q   <= drop_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench: per-cycle vector table for a 2-source / timeout-4 instance,
// plus hand sequences for async reset, a 3-source round robin and a long stall
// with the watchdog disabled.
module tb_tx_frame_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: N_REQ=2, TIMEOUT_CYCLES=4
  logic [127:0] a_tdata;
  logic [15:0]  a_tkeep;
  logic [1:0]   a_tvalid, a_tlast, a_s_tready, a_grant;
  logic [63:0]  a_m_tdata;
  logic [7:0]   a_m_tkeep;
  logic         a_m_tvalid, a_m_tlast, a_m_tuser, a_m_tready, a_abort;

  tx_frame_arbiter #(
    .N_REQ(2), .DATA_BYTES(8), .TIMEOUT_CYCLES(4)
  ) u_dut_a (
    .i_clk(clk), .i_reset(rst),
    .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
    .s_axis_tlast(a_tlast), .s_axis_tready(a_s_tready),
    .m00_axis_tdata(a_m_tdata), .m00_axis_tkeep(a_m_tkeep), .m00_axis_tvalid(a_m_tvalid),
    .m00_axis_tlast(a_m_tlast), .m00_axis_tuser(a_m_tuser), .m00_axis_tready(a_m_tready),
    .o_grant(a_grant), .o_abort(a_abort)
  );

  // Instance B: N_REQ=3, watchdog disabled
  logic [191:0] b_tdata;
  logic [23:0]  b_tkeep;
  logic [2:0]   b_tvalid, b_tlast, b_s_tready, b_grant;
  logic [63:0]  b_m_tdata;
  logic [7:0]   b_m_tkeep;
  logic         b_m_tvalid, b_m_tlast, b_m_tuser, b_m_tready, b_abort;

  tx_frame_arbiter #(
    .N_REQ(3), .DATA_BYTES(8), .TIMEOUT_CYCLES(0)
  ) u_dut_b (
    .i_clk(clk), .i_reset(rst),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
    .s_axis_tlast(b_tlast), .s_axis_tready(b_s_tready),
    .m00_axis_tdata(b_m_tdata), .m00_axis_tkeep(b_m_tkeep), .m00_axis_tvalid(b_m_tvalid),
    .m00_axis_tlast(b_m_tlast), .m00_axis_tuser(b_m_tuser), .m00_axis_tready(b_m_tready),
    .o_grant(b_grant), .o_abort(b_abort)
  );

  // {tvalid, tdata, tkeep, tlast, tuser, grant, s_tready, abort}
  logic [79:0] act_a;
  assign act_a = {a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tuser,
                  a_grant, a_s_tready, a_abort};

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] t0;
    logic [7:0] t1;
    logic [7:0] k1;
    logic       rdy;
    logic       ev;
    logic [7:0] et;
    logic [7:0] ek;
    logic       el;
    logic       eu;
    logic [1:0] eg;
    logic [1:0] er;
    logic       ea;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] v, input logic [1:0] l, input logic [7:0] t0,
                     input logic [7:0] t1, input logic [7:0] k1, input logic rdy,
                     input logic ev, input logic [7:0] et, input logic [7:0] ek,
                     input logic el, input logic eu, input logic [1:0] eg,
                     input logic [1:0] er, input logic ea);
    vec_t x;
    x.v = v; x.l = l; x.t0 = t0; x.t1 = t1; x.k1 = k1; x.rdy = rdy;
    x.ev = ev; x.et = et; x.ek = ek; x.el = el; x.eu = eu;
    x.eg = eg; x.er = er; x.ea = ea;
    vq.push_back(x);
  endtask

  task automatic set_a(input logic [1:0] v, input logic [1:0] l, input logic [7:0] t0,
                       input logic [7:0] t1, input logic [7:0] k1, input logic rdy);
    a_tvalid   = v;
    a_tlast    = l;
    a_tdata    = {{8{t1}}, {8{t0}}};
    a_tkeep    = {k1, 8'hFF};
    a_m_tready = rdy;
  endtask

  task automatic set_b(input logic [2:0] v, input logic [2:0] l, input logic [7:0] tag);
    b_tvalid   = v;
    b_tlast    = l;
    b_tdata    = {{8{tag}}, {8{tag}}, {8{tag}}};
    b_tkeep    = '1;
    b_m_tready = 1'b1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] exp;
    logic [2:0]  seen[$];
    int          stall_err;

    set_a(2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b0);
    set_b(3'b000, 3'b000, 8'h00);

    // Arbitration of two 3-beat frames, backpressure on source 1, then an
    // immediate re-grant of source 0 once round robin passes back to it.
    add(2'b11, 2'b00, 8'h11, 8'h21, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 8'h11, 8'h21, 8'hFF, 1, 1, 8'h11, 8'hFF, 0, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b00, 8'h12, 8'h21, 8'hFF, 1, 1, 8'h12, 8'hFF, 0, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b01, 8'h13, 8'h21, 8'hFF, 1, 1, 8'h13, 8'hFF, 1, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b01, 8'h14, 8'h21, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b01, 8'h14, 8'h21, 8'hFF, 1, 1, 8'h21, 8'hFF, 0, 0, 2'b10, 2'b10, 0);
    add(2'b11, 2'b11, 8'h14, 8'h22, 8'hFF, 0, 1, 8'h22, 8'hFF, 1, 0, 2'b10, 2'b00, 0);
    add(2'b11, 2'b11, 8'h14, 8'h22, 8'hFF, 1, 1, 8'h22, 8'hFF, 1, 0, 2'b10, 2'b10, 0);
    add(2'b01, 2'b01, 8'h14, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b01, 2'b01, 8'h14, 8'h00, 8'hFF, 1, 1, 8'h14, 8'hFF, 1, 0, 2'b01, 2'b01, 0);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    // Single-beat frame held under 10 cycles of backpressure: no abort.
    add(2'b10, 2'b10, 8'h00, 8'h31, 8'h0F, 0, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 10; i++)
      add(2'b10, 2'b10, 8'h00, 8'h31, 8'h0F, 0, 1, 8'h31, 8'h0F, 1, 0, 2'b10, 2'b00, 0);
    add(2'b10, 2'b10, 8'h00, 8'h31, 8'h0F, 1, 1, 8'h31, 8'h0F, 1, 0, 2'b10, 2'b10, 0);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    // Source 0 stalls after 2 beats: 4 idle cycles, held abort beat, drain.
    add(2'b11, 2'b00, 8'h41, 8'h51, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 2'b00, 8'h41, 8'h51, 8'hFF, 1, 1, 8'h41, 8'hFF, 0, 0, 2'b01, 2'b01, 0);
    add(2'b11, 2'b00, 8'h42, 8'h51, 8'hFF, 1, 1, 8'h42, 8'hFF, 0, 0, 2'b01, 2'b01, 0);
    for (int i = 0; i < 4; i++)
      add(2'b10, 2'b00, 8'h00, 8'h51, 8'hFF, 1, 0, 8'h00, 8'hFF, 0, 0, 2'b01, 2'b01, 0);
    add(2'b10, 2'b00, 8'h00, 8'h51, 8'hFF, 0, 1, 8'h00, 8'hFF, 1, 1, 2'b01, 2'b00, 0);
    add(2'b10, 2'b00, 8'h00, 8'h51, 8'hFF, 1, 1, 8'h00, 8'hFF, 1, 1, 2'b01, 2'b00, 1);
    add(2'b11, 2'b00, 8'h43, 8'h51, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b01, 0);
    add(2'b11, 2'b00, 8'h44, 8'h51, 8'hFF, 1, 1, 8'h51, 8'hFF, 0, 0, 2'b10, 2'b11, 0);
    add(2'b11, 2'b11, 8'h45, 8'h52, 8'hFF, 1, 1, 8'h52, 8'hFF, 1, 0, 2'b10, 2'b11, 0);
    add(2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 2'b00, 2'b00, 0);

    #12;
    check("reset_a", 128'(act_a), 128'(0));
    check("reset_b", 128'({b_m_tvalid, b_m_tdata, b_grant, b_s_tready, b_abort}), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk);
      #1;
      set_a(vq[k].v, vq[k].l, vq[k].t0, vq[k].t1, vq[k].k1, vq[k].rdy);
      @(negedge clk);
      exp = {vq[k].ev, {8{vq[k].et}}, vq[k].ek, vq[k].el, vq[k].eu,
             vq[k].eg, vq[k].er, vq[k].ea};
      check($sformatf("vec%0d", k), 128'(act_a), 128'(exp));
    end

    // Asynchronous reset in the middle of a source 1 frame.
    @(posedge clk); #1;
    set_a(2'b10, 2'b00, 8'h00, 8'h61, 8'hFF, 1'b1);
    @(posedge clk); #1;
    set_a(2'b10, 2'b00, 8'h00, 8'h62, 8'hFF, 1'b1);
    @(negedge clk);
    check("rst_pre_grant", 128'(a_grant), 128'(2'b10));
    #2 rst = 1'b1;
    #1 check("rst_async_zero", 128'(act_a), 128'(0));
    set_a(2'b11, 2'b01, 8'h71, 8'h62, 8'hFF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle_after", 128'(act_a), 128'(0));
    @(negedge clk);
    check("rst_first_grant", 128'(a_grant), 128'(2'b01));
    check("rst_first_data", 128'(a_m_tdata), 128'({8{8'h71}}));
    @(posedge clk); #1;
    set_a(2'b00, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b0);

    // N_REQ=3: sources 0 and 2 request single-beat frames back to back.
    @(posedge clk); #1;
    set_b(3'b101, 3'b111, 8'h90);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("b_no_src1_c%0d", c), 128'(b_grant[1]), 128'(0));
      if (b_grant != 3'b000) seen.push_back(b_grant);
    end
    check("b_grant_count", 128'(seen.size()), 128'(5));
    for (int i = 0; i < seen.size(); i++)
      check($sformatf("b_order%0d", i), 128'(seen[i]), 128'((i % 2 == 0) ? 3'b001 : 3'b100));
    @(posedge clk); #1;
    set_b(3'b000, 3'b000, 8'h00);

    // Watchdog disabled: source 1 stalls for 1000 cycles mid-frame.
    @(posedge clk); #1;
    set_b(3'b010, 3'b000, 8'h81);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_b(3'b000, 3'b000, 8'h00);
    stall_err = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (b_grant !== 3'b010 || b_abort !== 1'b0 || b_m_tvalid !== 1'b0) stall_err++;
    end
    check("b_stall_hold", 128'(stall_err), 128'(0));
    @(posedge clk); #1;
    set_b(3'b010, 3'b010, 8'h82);
    @(negedge clk);
    check("b_resume_beat", 128'({b_m_tvalid, b_m_tlast, b_m_tuser, b_m_tdata, b_grant}),
          128'({1'b1, 1'b1, 1'b0, {8{8'h82}}, 3'b010}));
    @(posedge clk); #1;
    set_b(3'b000, 3'b000, 8'h00);
    @(negedge clk);
    check("b_release", 128'(b_grant), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares the single Tx MAC AXIS input between N_REQ independent AXIS frame sources (e.g. host path and loopback/test generator).
- Sits directly upstream of the Tx MAC, in the MAC clock domain.
- Contains a stall watchdog: a granted source that stops mid-frame has its frame terminated with an error beat, so it cannot hold the MAC indefinitely.

Parameters:
- N_REQ, 2, number of requesting AXIS sources (2..8).
- DATA_BYTES, 8, AXIS byte lanes; tdata width is DATA_BYTES*8.
- TIMEOUT_CYCLES, 64, consecutive granted-but-idle cycles before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  MAC clock.
- i_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  N_REQ*64  per-source data; source i occupies [i*64 +: 64].
- s_axis_tkeep  in  N_REQ*8  per-source byte enables.
- s_axis_tvalid  in  N_REQ  per-source valid.
- s_axis_tlast  in  N_REQ  per-source end of frame.
- s_axis_tready  out  N_REQ  per-source ready.
- m00_axis_tdata  out  64  to Tx MAC.
- m00_axis_tkeep  out  8  to Tx MAC.
- m00_axis_tvalid  out  1  to Tx MAC.
- m00_axis_tlast  out  1  to Tx MAC.
- m00_axis_tuser  out  1  1 marks an aborted frame; MAC must corrupt FCS or drop.
- m00_axis_tready  in  1  from Tx MAC.
- o_grant  out  N_REQ  one-hot current owner; 0 when idle.
- o_abort  out  1  single-cycle pulse when the abort beat is accepted.

Behaviour:
- Reset (asynchronous, active-high): all outputs are driven 0 immediately.
  - State is IDLE, rr_ptr=0, drop[]=0, timer=0.
  - Reset mid-frame truncates output with no tlast; the downstream MAC is reset together with this block.
- State IDLE:
  - Eligible set: s_axis_tvalid[i] & ~drop[i].
  - Winner: the first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - If any source is eligible, grant is registered: go to FWD and set o_grant, effective next cycle. Arbitration latency is 1 cycle.
  - In IDLE, m00_axis_tvalid=0 and s_axis_tready[i]=drop[i].
- State FWD (owner g):
  - Combinational pass-through: m00 tdata/tkeep/tvalid/tlast come from source g; m00_axis_tuser=0.
  - s_axis_tready[g]=m00_axis_tready; other sources get tready=drop[i].
  - A handshake with tlast=1 moves to IDLE, sets rr_ptr=(g+1) mod N_REQ and clears o_grant.
  - A single-beat frame (tlast on the first beat) is legal.
- Watchdog (only when TIMEOUT_CYCLES != 0):
  - timer counts cycles in FWD where s_axis_tvalid[g]=0.
  - timer clears on any accepted beat and on entry to FWD.
  - Cycles with s_axis_tvalid[g]=1 but m00_axis_tready=0 do not count; downstream backpressure never aborts.
  - When timer reaches TIMEOUT_CYCLES-1 and the source is still not valid, go to ABORT. The timer is sized $clog2(TIMEOUT_CYCLES+1).
- State ABORT (owner g):
  - Drive m00 tvalid=1, tdata=0, tkeep=8'hFF, tlast=1, tuser=1; s_axis_tready[g]=0.
  - Hold this beat until m00_axis_tready=1.
  - On acceptance: pulse o_abort, set drop[g]=1, set rr_ptr=(g+1) mod N_REQ, go to IDLE.
- Drop mode (per source):
  - While drop[i]=1 (any state, including while another source is granted), s_axis_tready[i]=1 and beats are discarded.
  - drop[i] clears on a discarded beat with tlast=1; source i is eligible from the following cycle.
  - If source i resumes with its tlast beat in the same cycle drop is set, that beat is discarded on the next cycle; drop remains the authority.
- Boundary conditions:
  - All sources valid continuously gives strict alternation by frame.
  - N_REQ=1 degenerates to pass-through with 1-cycle grant latency per frame.
  - rr_ptr wraps modulo N_REQ; this is non-power-of-2 safe.
  - tkeep is not checked; it is forwarded as-is.

Decomposition:
- New package mac_arb_pkg:
  - typedef arb_state_t {IDLE, FWD, ABORT}.
  - Constant ABORT_KEEP=8'hFF.
- Sub-module rr_select (parameter N): combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, index, any_valid.
  - Reused by future Tx queue schedulers.

Test Plan:
- Both sources present a 3-beat frame at cycle 0, rr_ptr=0 → o_grant=01 at cycle 1. Beats of source 0 are on m00 in cycles 1-3 with tlast in cycle 3. o_grant=10 at cycle 5, and source 1 is forwarded next.
- Source 1 sends a 1-beat frame (tkeep=8'h0F, tlast=1) with m00_axis_tready held 0 for 10 cycles → beat held stable with tvalid=1, no abort, and it is accepted on the first ready cycle.
- TIMEOUT_CYCLES=4: source 0 sends 2 beats then drops tvalid → after 4 idle cycles, m00 shows tdata=0, tkeep=FF, tlast=1, tuser=1. o_abort pulses once. Source 0's late 3 beats are accepted with m00_axis_tvalid=0 for them. Source 1's pending frame is granted right after the abort.
- Assert i_reset asynchronously mid-beat of source 1's frame → all m00 outputs, s_axis_tready and o_grant are 0 in the same cycle. After release, the first grant goes to source 0 (rr_ptr=0).
- TIMEOUT_CYCLES=0 with a source stalled for 1000 cycles mid-frame → no abort, grant held, frame completes normally when the source resumes.
- N_REQ=3, sources 0 and 2 continuously requesting, source 1 idle → grant order is 0,2,0,2 and source 1 is never granted.
